// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the regional clock divider.
package clk_div_pkg;

  localparam int unsigned MAX_DIVIDE = 8;

  typedef logic [2:0] phase_t;
  typedef logic [3:0] lock_cnt_t;

  // Number of high phases per divided period: ceil(divide/2).
  function automatic phase_t half_high(input int unsigned divide);
    return phase_t'((divide + 1) / 2);
  endfunction

endpackage

// File: rtl/clk_div_lock_mon.sv
// Counts uninterrupted divided periods and raises a sticky lock flag.
module clk_div_lock_mon
  import clk_div_pkg::*;
#(
  parameter int unsigned LOCK_PERIODS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ce_int_i,
  input  logic wrap_i,
  output logic lock_o
);

  localparam lock_cnt_t LOCK_TARGET = lock_cnt_t'(LOCK_PERIODS);

  lock_cnt_t cnt_q, cnt_d;
  logic      lock_q, lock_d;

  always_comb begin
    cnt_d  = cnt_q;
    lock_d = lock_q;
    if (!lock_q) begin
      if (!ce_int_i) begin
        cnt_d = '0;
      end else if (wrap_i) begin
        cnt_d = cnt_q + 1'b1;
      end
      // Counter saturates at the target because lock_q freezes it next cycle.
      lock_d = (cnt_d == LOCK_TARGET);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
    end
  end

  assign lock_o = lock_q;

endmodule

// File: rtl/regional_clk_div.sv
// Regional clock divider with clock enable, async clear, rise strobe,
// phase index and lock indication.
module regional_clk_div
  import clk_div_pkg::*;
#(
  parameter int unsigned DIVIDE       = 4,
  parameter int unsigned LOCK_PERIODS = 4,
  parameter int unsigned CE_LATENCY   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  output logic       clk_div_o,
  output logic       rise_stb_o,
  output logic [2:0] phase_o,
  output logic       lock_o
);

  if (DIVIDE < 1 || DIVIDE > MAX_DIVIDE) begin : g_bad_divide
    $fatal(1, "regional_clk_div: DIVIDE must be 1..8");
  end
  if (LOCK_PERIODS < 1 || LOCK_PERIODS > 15) begin : g_bad_lock
    $fatal(1, "regional_clk_div: LOCK_PERIODS must be 1..15");
  end
  if (CE_LATENCY > 1) begin : g_bad_ce_lat
    $fatal(1, "regional_clk_div: CE_LATENCY must be 0 or 1");
  end

  localparam phase_t LAST_PHASE = phase_t'(DIVIDE - 1);
  localparam phase_t HIGH_PHASES = half_high(DIVIDE);

  logic   ce_q;
  logic   ce_int;
  phase_t phase_q, phase_d;
  logic   clk_div_q, clk_div_d;
  logic   rise_stb_q, rise_stb_d;
  logic   started_q, started_d;
  logic   wrap;

  always_comb begin
    ce_int     = (CE_LATENCY == 0) ? ce : ce_q;
    wrap       = ce_int && (phase_q == LAST_PHASE);
    phase_d    = phase_q;
    clk_div_d  = clk_div_q;
    rise_stb_d = 1'b0;
    started_d  = started_q;
    if (ce_int) begin
      phase_d    = wrap ? '0 : phase_q + 1'b1;
      clk_div_d  = (phase_d < HIGH_PHASES);
      // The very first enabled count is a 0->1 edge of clk_div_o as well.
      rise_stb_d = wrap || !started_q;
      started_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_q       <= 1'b0;
      phase_q    <= '0;
      clk_div_q  <= 1'b0;
      rise_stb_q <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      ce_q       <= ce;
      phase_q    <= phase_d;
      clk_div_q  <= clk_div_d;
      rise_stb_q <= rise_stb_d;
      started_q  <= started_d;
    end
  end

  clk_div_lock_mon #(
    .LOCK_PERIODS(LOCK_PERIODS)
  ) u_lock_mon (
    .clk     (clk),
    .rst     (rst),
    .ce_int_i(ce_int),
    .wrap_i  (wrap),
    .lock_o  (lock_o)
  );

  assign clk_div_o  = clk_div_q;
  assign rise_stb_o = rise_stb_q;
  assign phase_o    = phase_q;

endmodule

// File: tb/tb_regional_clk_div.sv
// Directed self-checking bench for regional_clk_div (DIVIDE 4, 5 and 1).
module tb_regional_clk_div;

  logic       clk = 1'b0;
  logic       rst4, ce4, div4, stb4, lk4;
  logic       rst5, ce5, div5, stb5, lk5;
  logic       rst1, ce1, div1, stb1, lk1;
  logic [2:0] ph4, ph5, ph1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regional_clk_div #(.DIVIDE(4), .LOCK_PERIODS(4), .CE_LATENCY(1)) u4 (
    .clk(clk), .rst(rst4), .ce(ce4), .clk_div_o(div4), .rise_stb_o(stb4),
    .phase_o(ph4), .lock_o(lk4));

  regional_clk_div #(.DIVIDE(5), .LOCK_PERIODS(4), .CE_LATENCY(1)) u5 (
    .clk(clk), .rst(rst5), .ce(ce5), .clk_div_o(div5), .rise_stb_o(stb5),
    .phase_o(ph5), .lock_o(lk5));

  regional_clk_div #(.DIVIDE(1), .LOCK_PERIODS(4), .CE_LATENCY(0)) u1 (
    .clk(clk), .rst(rst1), .ce(ce1), .clk_div_o(div1), .rise_stb_o(stb1),
    .phase_o(ph1), .lock_o(lk1));

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input int k, input logic [2:0] ph,
                      input logic dv, input logic st, input logic lk);
    chk({tag, ".phase"}, k, 32'(ph4), 32'(ph));
    chk({tag, ".div"},   k, 32'(div4), 32'(dv));
    chk({tag, ".stb"},   k, 32'(stb4), 32'(st));
    chk({tag, ".lock"},  k, 32'(lk4), 32'(lk));
  endtask

  // Undisturbed DIVIDE=4 run, k = clk edges since rst release, ce held high.
  task automatic exp4(input string tag, input int k);
    int ph;
    if (k == 1) begin
      chk4(tag, k, 3'd0, 1'b0, 1'b0, 1'b0);
    end else begin
      ph = (k - 1) % 4;
      chk4(tag, k, 3'(ph), ph < 2, (k == 2) || (ph == 0), k >= 17);
    end
  endtask

  initial begin
    rst4 = 1'b1; rst5 = 1'b1; rst1 = 1'b1;
    ce4  = 1'b1; ce5  = 1'b1; ce1  = 1'b1;
    repeat (2) tick();
    chk4("d4_reset", 0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("d1_reset.div", 0, 32'(div1), 32'd0);

    // DIVIDE=4 power-on start through lock
    rst4 = 1'b0;
    for (int k = 1; k <= 27; k++) begin
      tick();
      exp4("d4_run", k);
    end

    // Async clear between edges at phase 2 with lock set
    #2 rst4 = 1'b1;
    #1 chk4("d4_async_rst", 0, 3'd0, 1'b0, 1'b0, 1'b0);
    #2 rst4 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp4("d4_restart", k);
    end

    // ce low for three clocks at phase 1, before lock
    ce4 = 1'b0;
    tick(); exp4("d4_restart", 6);
    tick(); chk4("d4_ce_hold", 7, 3'd1, 1'b1, 1'b0, 1'b0);
    tick(); chk4("d4_ce_hold", 8, 3'd1, 1'b1, 1'b0, 1'b0);
    ce4 = 1'b1;
    tick(); chk4("d4_ce_hold", 9, 3'd1, 1'b1, 1'b0, 1'b0);
    tick(); chk4("d4_resume", 10, 3'd2, 1'b0, 1'b0, 1'b0);
    tick(); chk4("d4_resume", 11, 3'd3, 1'b0, 1'b0, 1'b0);
    tick(); chk4("d4_resume", 12, 3'd0, 1'b1, 1'b1, 1'b0);
    repeat (11) tick();
    chk("d4_relock_early.lock", 23, 32'(lk4), 32'd0);
    tick();
    chk("d4_relock.lock", 24, 32'(lk4), 32'd1);

    // ce dropped on the wrap cycle
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp4("d4_wrapdrop_pre", k);
    end
    ce4 = 1'b0;
    tick(); exp4("d4_wrapdrop_pre", 4);
    ce4 = 1'b1;
    tick(); chk4("d4_wrapdrop_hold", 5, 3'd3, 1'b0, 1'b0, 1'b0);
    tick(); chk4("d4_wrapdrop_wrap", 6, 3'd0, 1'b1, 1'b1, 1'b0);
    repeat (11) tick();
    chk("d4_wrapdrop_early.lock", 17, 32'(lk4), 32'd0);
    tick();
    chk("d4_wrapdrop.lock", 18, 32'(lk4), 32'd1);

    // DIVIDE=5: 3 high / 2 low, strobe every 5 clocks, 20 periods
    rst5 = 1'b0;
    for (int k = 1; k <= 102; k++) begin
      int ph;
      tick();
      ph = (k == 1) ? 0 : (k - 1) % 5;
      chk("d5.phase", k, 32'(ph5), 32'(ph));
      chk("d5.div",   k, 32'(div5), (k == 1) ? 32'd0 : 32'(ph < 3));
      chk("d5.stb",   k, 32'(stb5), (k == 1) ? 32'd0 : 32'((k == 2) || (ph == 0)));
      chk("d5.lock",  k, 32'(lk5), 32'(k >= 21));
    end

    // DIVIDE=1, no CE latency
    rst1 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("d1.phase", k, 32'(ph1), 32'd0);
      chk("d1.div",   k, 32'(div1), 32'd1);
      chk("d1.stb",   k, 32'(stb1), 32'd1);
      chk("d1.lock",  k, 32'(lk1), 32'(k >= 4));
    end
    ce1 = 1'b0;
    for (int k = 7; k <= 8; k++) begin
      tick();
      chk("d1_ce_off.div", k, 32'(div1), 32'd1);
      chk("d1_ce_off.stb", k, 32'(stb1), 32'd0);
      chk("d1_ce_off.lock", k, 32'(lk1), 32'd1);
    end
    ce1 = 1'b1;
    tick();
    chk("d1_ce_on.stb", 9, 32'(stb1), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
